// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types, LFSR tap table and MISR polynomial for the BIST sequencer
package bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, CMP} bist_state_t;

  // Signature shift polynomial for the 16-bit MISR
  localparam logic [15:0] MISR_POLY = 16'h1021;

  // One tap (numbered from 1) as a bit mask; tap number 0 means unused
  function automatic logic [63:0] tap(input int n);
    tap = (n > 0) ? (64'd1 << (n - 1)) : 64'd0;
  endfunction

  function automatic logic [63:0] taps4(input int a, input int b, input int c, input int d);
    taps4 = tap(a) | tap(b) | tap(c) | tap(d);
  endfunction

  // Maximal-length Fibonacci tap mask for an LFSR of width w
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      2:  lfsr_taps = taps4(2, 1, 0, 0);
      3:  lfsr_taps = taps4(3, 2, 0, 0);
      4:  lfsr_taps = taps4(4, 3, 0, 0);
      5:  lfsr_taps = taps4(5, 3, 0, 0);
      6:  lfsr_taps = taps4(6, 5, 0, 0);
      7:  lfsr_taps = taps4(7, 6, 0, 0);
      8:  lfsr_taps = taps4(8, 6, 5, 4);
      9:  lfsr_taps = taps4(9, 5, 0, 0);
      10: lfsr_taps = taps4(10, 7, 0, 0);
      11: lfsr_taps = taps4(11, 9, 0, 0);
      12: lfsr_taps = taps4(12, 6, 4, 1);
      13: lfsr_taps = taps4(13, 4, 3, 1);
      14: lfsr_taps = taps4(14, 5, 3, 1);
      15: lfsr_taps = taps4(15, 14, 0, 0);
      16: lfsr_taps = taps4(16, 15, 13, 4);
      17: lfsr_taps = taps4(17, 14, 0, 0);
      18: lfsr_taps = taps4(18, 11, 0, 0);
      19: lfsr_taps = taps4(19, 6, 2, 1);
      20: lfsr_taps = taps4(20, 17, 0, 0);
      21: lfsr_taps = taps4(21, 19, 0, 0);
      22: lfsr_taps = taps4(22, 21, 0, 0);
      23: lfsr_taps = taps4(23, 18, 0, 0);
      24: lfsr_taps = taps4(24, 23, 22, 17);
      25: lfsr_taps = taps4(25, 22, 0, 0);
      26: lfsr_taps = taps4(26, 6, 2, 1);
      27: lfsr_taps = taps4(27, 5, 2, 1);
      28: lfsr_taps = taps4(28, 25, 0, 0);
      29: lfsr_taps = taps4(29, 27, 0, 0);
      30: lfsr_taps = taps4(30, 6, 4, 1);
      31: lfsr_taps = taps4(31, 28, 0, 0);
      32: lfsr_taps = taps4(32, 22, 2, 1);
      33: lfsr_taps = taps4(33, 20, 0, 0);
      34: lfsr_taps = taps4(34, 27, 2, 1);
      35: lfsr_taps = taps4(35, 33, 0, 0);
      36: lfsr_taps = taps4(36, 25, 0, 0);
      37: lfsr_taps = taps4(37, 5, 4, 3) | taps4(2, 1, 0, 0);
      38: lfsr_taps = taps4(38, 6, 5, 1);
      39: lfsr_taps = taps4(39, 35, 0, 0);
      40: lfsr_taps = taps4(40, 38, 21, 19);
      41: lfsr_taps = taps4(41, 38, 0, 0);
      42: lfsr_taps = taps4(42, 41, 20, 19);
      43: lfsr_taps = taps4(43, 42, 38, 37);
      44: lfsr_taps = taps4(44, 43, 18, 17);
      45: lfsr_taps = taps4(45, 44, 42, 41);
      46: lfsr_taps = taps4(46, 45, 26, 25);
      47: lfsr_taps = taps4(47, 42, 0, 0);
      48: lfsr_taps = taps4(48, 47, 21, 20);
      49: lfsr_taps = taps4(49, 40, 0, 0);
      50: lfsr_taps = taps4(50, 49, 24, 23);
      51: lfsr_taps = taps4(51, 50, 36, 35);
      52: lfsr_taps = taps4(52, 49, 0, 0);
      53: lfsr_taps = taps4(53, 52, 38, 37);
      54: lfsr_taps = taps4(54, 53, 18, 17);
      55: lfsr_taps = taps4(55, 31, 0, 0);
      56: lfsr_taps = taps4(56, 55, 35, 34);
      57: lfsr_taps = taps4(57, 50, 0, 0);
      58: lfsr_taps = taps4(58, 39, 0, 0);
      59: lfsr_taps = taps4(59, 58, 38, 37);
      60: lfsr_taps = taps4(60, 59, 0, 0);
      61: lfsr_taps = taps4(61, 60, 46, 45);
      62: lfsr_taps = taps4(62, 61, 6, 5);
      63: lfsr_taps = taps4(63, 62, 0, 0);
      64: lfsr_taps = taps4(64, 63, 61, 60);
      default: lfsr_taps = taps4(w, w - 1, 0, 0);
    endcase
  endfunction

  // MISR feedback polynomial by signature width
  function automatic logic [63:0] misr_poly(input int w);
    case (w)
      8:       misr_poly = 64'h1D;
      16:      misr_poly = {48'd0, MISR_POLY};
      32:      misr_poly = 64'h04C1_1DB7;
      default: misr_poly = 64'h3;
    endcase
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// rtl/bist_lfsr.sv - Fibonacci LFSR pattern source with seed load and single-step control
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int              WIDTH = 35,
  parameter logic [WIDTH-1:0] SEED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] next_state,
  output logic [WIDTH-1:0] seed_state
);

  localparam logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH));
  // An all-zero seed would lock the register, so it is promoted to 1
  localparam logic [WIDTH-1:0] START = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] state;

  assign next_state = {state[WIDTH-2:0], ^(state & TAPS)};
  assign seed_state = START;

  // Pattern register: restart from the seed on load, advance one step on request
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= START;
    end else if (load) begin
      state <= START;
    end else if (step) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/netlist_bist_ctrl.sv
// rtl/netlist_bist_ctrl.sv - BIST sequencer: LFSR vectors in, MISR signature out, golden compare
module netlist_bist_ctrl
  import bist_pkg::*;
#(
  parameter int                N_IN        = 35,
  parameter int                N_OUT       = 1,
  parameter int                MISR_W      = 16,
  parameter int                PATTERN_CNT = 1024,
  parameter int                SETTLE_CYC  = 1,
  parameter logic [N_IN-1:0]   LFSR_SEED   = 1,
  parameter logic [MISR_W-1:0] GOLDEN      = '0,
  localparam int               PW          = $clog2(PATTERN_CNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [PW-1:0]     pat_idx,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out
);

  localparam int                SW          = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_CYC);
  localparam logic [PW-1:0]     PAT_LAST    = PW'(PATTERN_CNT - 1);
  localparam logic [PW-1:0]     PAT_END     = PW'(PATTERN_CNT);
  localparam logic [MISR_W-1:0] POLY        = MISR_W'(misr_poly(MISR_W));

  bist_state_t       state, state_next;
  logic [SW-1:0]     settle_cnt;
  logic [MISR_W-1:0] misr, misr_fb, misr_step;
  logic [N_IN-1:0]   lfsr_next, lfsr_seed;
  logic              load, capture, finish, cancel;

  bist_lfsr #(
    .WIDTH (N_IN),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (capture),
    .next_state (lfsr_next),
    .seed_state (lfsr_seed)
  );

  assign misr_fb   = misr[MISR_W-1] ? POLY : '0;
  assign misr_step = {misr[MISR_W-2:0], misr[MISR_W-1]} ^ misr_fb ^ MISR_W'(dut_out);
  assign busy      = (state != IDLE);
  assign signature = misr;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle strobes; abort always takes priority over start and capture
  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    cancel     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          cancel     = 1'b1;
          state_next = IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          capture = 1'b1;
          if (pat_idx == PAT_LAST) begin
            state_next = CMP;
          end
        end
      end
      CMP: begin
        if (abort) begin
          cancel = 1'b1;
        end else begin
          finish = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Settle and pattern counters; pat_idx parks at PATTERN_CNT once the run has captured everything
  always_ff @(posedge clk) begin
    if (rst || load) begin
      settle_cnt <= '0;
      pat_idx    <= '0;
    end else if (capture) begin
      settle_cnt <= '0;
      if (pat_idx != PAT_END) begin
        pat_idx <= pat_idx + 1'b1;
      end
    end else if (state == RUN && !abort) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Signature, applied vector, verdict and end-of-run pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      misr   <= '0;
      dut_in <= '0;
      pass   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        misr   <= '0;
        dut_in <= lfsr_seed;
        pass   <= 1'b0;
      end else if (capture) begin
        misr   <= misr_step;
        dut_in <= lfsr_next;
      end else if (cancel) begin
        dut_in <= '0;
      end
      if (finish) begin
        pass <= (misr == GOLDEN);
      end
    end
  end

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// tb/tb_netlist_bist_ctrl.sv - scoreboard bench for the BIST sequencer against a behavioural model
module tb_netlist_bist_ctrl;

  localparam int          M_CNT  = 8;
  localparam int          M_SET  = 2;
  localparam int          M_LEN  = M_CNT * (M_SET + 1) + 1;
  localparam logic [7:0]  M_SEED = 8'h5A;
  localparam logic [15:0] M_GOLD = 16'h0000;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_start = 1'b0, a_abort = 1'b0;
  logic s_start = 1'b0;
  logic m_start = 1'b0, m_abort = 1'b0;

  logic        a_busy, a_done, a_pass;
  logic [15:0] a_sig;
  logic [2:0]  a_pat;
  logic [34:0] a_in;

  logic        b_busy, b_done, b_pass, c_busy, c_done, c_pass;
  logic [15:0] b_sig, c_sig;
  logic [0:0]  b_pat, c_pat;
  logic [34:0] b_in, c_in;

  logic        d_busy, d_done, d_pass;
  logic [15:0] d_sig;
  logic [3:0]  d_pat, d_in, d_out;

  logic        m_busy, m_done, m_pass;
  logic [15:0] m_sig_o;
  logic [3:0]  m_pat;
  logic [7:0]  m_in;
  logic [2:0]  m_out;

  // Stand-in combinational netlists
  function automatic logic [2:0] m_net(input logic [7:0] v);
    return {^(v & 8'hC3), v[7] & v[0], v[3] | v[4]};
  endfunction

  function automatic logic [3:0] d_net(input logic [3:0] v);
    return v ^ {v[0], v[3:1]};
  endfunction

  assign m_out = m_net(m_in);
  assign d_out = d_net(d_in);

  // Reference: x^8+x^6+x^5+x^4 and x^4+x^3 recurrences, newest bit enters at the bottom
  function automatic logic [7:0] m_lfsr(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [3:0] d_lfsr(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  function automatic logic [15:0] misr_model(input logic [15:0] m, input logic [15:0] o);
    logic [15:0] r;
    r = {m[14:0], m[15]};
    if (m[15]) r = r ^ 16'h1021;
    return r ^ o;
  endfunction

  function automatic logic [15:0] m_expect(input int caps);
    logic [7:0]  v;
    logic [15:0] m;
    v = M_SEED;
    m = '0;
    for (int i = 0; i < caps; i++) begin
      m = misr_model(m, {13'd0, m_net(v)});
      v = m_lfsr(v);
    end
    return m;
  endfunction

  function automatic logic [15:0] d_expect();
    logic [3:0]  v;
    logic [15:0] m;
    v = 4'h1;
    m = '0;
    for (int i = 0; i < 15; i++) begin
      m = misr_model(m, {12'd0, d_net(v)});
      v = d_lfsr(v);
    end
    return m;
  endfunction

  netlist_bist_ctrl #(.N_IN(35), .N_OUT(1), .MISR_W(16), .PATTERN_CNT(4), .SETTLE_CYC(1),
                      .LFSR_SEED(35'd1), .GOLDEN(16'h0000)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .busy(a_busy), .done(a_done),
    .pass(a_pass), .signature(a_sig), .pat_idx(a_pat), .dut_in(a_in), .dut_out(1'b0));

  netlist_bist_ctrl #(.N_IN(35), .N_OUT(1), .MISR_W(16), .PATTERN_CNT(1), .SETTLE_CYC(0),
                      .LFSR_SEED(35'd1), .GOLDEN(16'h0001)) u_b (
    .clk(clk), .rst(rst), .start(s_start), .abort(1'b0), .busy(b_busy), .done(b_done),
    .pass(b_pass), .signature(b_sig), .pat_idx(b_pat), .dut_in(b_in), .dut_out(1'b1));

  netlist_bist_ctrl #(.N_IN(35), .N_OUT(1), .MISR_W(16), .PATTERN_CNT(1), .SETTLE_CYC(0),
                      .LFSR_SEED(35'd1), .GOLDEN(16'h0000)) u_c (
    .clk(clk), .rst(rst), .start(s_start), .abort(1'b0), .busy(c_busy), .done(c_done),
    .pass(c_pass), .signature(c_sig), .pat_idx(c_pat), .dut_in(c_in), .dut_out(1'b1));

  netlist_bist_ctrl #(.N_IN(4), .N_OUT(4), .MISR_W(16), .PATTERN_CNT(15), .SETTLE_CYC(0),
                      .LFSR_SEED(4'h0), .GOLDEN(16'h0000)) u_d (
    .clk(clk), .rst(rst), .start(s_start), .abort(1'b0), .busy(d_busy), .done(d_done),
    .pass(d_pass), .signature(d_sig), .pat_idx(d_pat), .dut_in(d_in), .dut_out(d_out));

  netlist_bist_ctrl #(.N_IN(8), .N_OUT(3), .MISR_W(16), .PATTERN_CNT(M_CNT), .SETTLE_CYC(M_SET),
                      .LFSR_SEED(M_SEED), .GOLDEN(M_GOLD)) u_m (
    .clk(clk), .rst(rst), .start(m_start), .abort(m_abort), .busy(m_busy), .done(m_done),
    .pass(m_pass), .signature(m_sig_o), .pat_idx(m_pat), .dut_in(m_in), .dut_out(m_out));

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles and done pulses of instance A, starting in the first cycle after a start edge
  task automatic a_observe(input int ncyc, output int busy_n, output int done_at, output int done_n);
    busy_n  = 0;
    done_at = -1;
    done_n  = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (a_busy) busy_n++;
      if (a_done) begin
        done_n++;
        done_at = c;
      end
      tick();
    end
  endtask

  // Monitor for instance M: on every done pulse pop the expected result and compare
  initial begin
    int   run_len;
    exp_t e;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_len = 0;
      end else begin
        if (m_done) begin
          if (sb.size() == 0) begin
            check("m_unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("m_signature", 64'(m_sig_o), 64'(e.sig));
            check("m_pass", 64'(m_pass), 64'(e.pass));
            check("m_busy_len", 64'(run_len), 64'(e.len));
          end
        end
        if (m_busy) run_len++;
        else run_len = 0;
      end
    end
  end

  // Directed scenarios on A/B/C/D, then randomized runs with aborts on M
  initial begin
    int         busy_n, done_at, done_n;
    int         b_n, c_n, d_n, d_at, n_vec, caps;
    logic [15:0] seen;
    bit          do_ab;
    int          ab_at;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_pass", 64'(a_pass), 64'd0);
    check("rst_sig", 64'(a_sig), 64'd0);
    check("rst_pat_idx", 64'(a_pat), 64'd0);
    check("rst_dut_in", 64'(a_in), 64'd0);

    // Basic timed run: busy 9 cycles starting the cycle after the start edge, done in cycle 10
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("a_first_vector", 64'(a_in), 64'd1);
    a_observe(12, busy_n, done_at, done_n);
    check("a_busy_cycles", 64'(busy_n), 64'd9);
    check("a_done_cycle", 64'(done_at), 64'd10);
    check("a_done_count", 64'(done_n), 64'd1);
    check("a_signature", 64'(a_sig), 64'd0);
    check("a_pass", 64'(a_pass), 64'd1);
    check("a_pat_idx_sat", 64'(a_pat), 64'd4);

    // Start and abort together in IDLE: abort wins
    a_start = 1'b1; a_abort = 1'b1; tick(); a_start = 1'b0; a_abort = 1'b0;
    check("a_start_abort_idle", 64'(a_busy), 64'd0);

    // Mid-run start ignored; start held across done begins a new run in the done cycle
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (2) tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (4) tick();
    a_start = 1'b1;
    repeat (2) tick();
    check("a_held_done", 64'(a_done), 64'd1);
    check("a_held_busy_in_done", 64'(a_busy), 64'd0);
    check("a_held_pass_at_done", 64'(a_pass), 64'd1);
    tick(); a_start = 1'b0;
    check("a_restart_busy", 64'(a_busy), 64'd1);
    check("a_restart_pass_clear", 64'(a_pass), 64'd0);
    a_observe(12, busy_n, done_at, done_n);
    check("a_restart_done_cycle", 64'(done_at), 64'd10);
    check("a_restart_pass", 64'(a_pass), 64'd1);

    // Reset in the middle of a run
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (4) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rstrun_busy", 64'(a_busy), 64'd0);
    check("rstrun_state", {a_done, a_pass, a_sig, a_pat}, 64'd0);
    check("rstrun_dut_in", 64'(a_in), 64'd0);
    a_observe(12, busy_n, done_at, done_n);
    check("rstrun_no_done", 64'(done_n), 64'd0);
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_observe(12, busy_n, done_at, done_n);
    check("rstrun_rerun_done", 64'(done_at), 64'd10);
    check("rstrun_rerun_busy", 64'(busy_n), 64'd9);

    // Single-pattern runs and the 4-bit full-period run share one start
    b_n = 0; c_n = 0; d_n = 0; d_at = -1; n_vec = 0; seen = '0;
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("d_first_vector", 64'(d_in), 64'h1);
    for (int c = 1; c <= 20; c++) begin
      if (d_busy && d_pat < 4'd15) begin
        seen[d_in] = 1'b1;
        n_vec++;
      end
      if (b_done) begin
        b_n++;
        check("b_signature", 64'(b_sig), 64'h1);
        check("b_pass", 64'(b_pass), 64'd1);
        check("b_done_cycle", 64'(c), 64'd3);
      end
      if (c_done) begin
        c_n++;
        check("c_signature", 64'(c_sig), 64'h1);
        check("c_pass", 64'(c_pass), 64'd0);
      end
      if (d_done) begin
        d_n++;
        d_at = c;
        check("d_signature", 64'(d_sig), 64'(d_expect()));
        check("d_pass", 64'(d_pass), 64'(d_expect() == 16'h0));
      end
      tick();
    end
    check("bcd_done_counts", {32'(b_n), 16'(c_n), 16'(d_n)}, {32'd1, 16'd1, 16'd1});
    check("d_done_cycle", 64'(d_at), 64'd17);
    check("d_vector_count", 64'(n_vec), 64'd15);
    check("d_distinct", 64'($countones(seen)), 64'd15);
    check("d_no_zero", 64'(seen[0]), 64'd0);

    // Randomized runs on M; run 0 aborts during vector 2
    for (int r = 0; r < 14; r++) begin
      do_ab = (r == 0) || ($urandom_range(0, 2) == 0);
      ab_at = (r == 0) ? 8 : int'($urandom_range(1, M_LEN));
      repeat ($urandom_range(0, 3)) tick();
      if (!do_ab) sb.push_back('{sig: m_expect(M_CNT), pass: (m_expect(M_CNT) == M_GOLD), len: M_LEN});
      m_start = 1'b1; tick(); m_start = 1'b0;
      for (int c = 1; c <= M_LEN; c++) begin
        if (c == 5 && $urandom_range(0, 1) == 1) m_start = 1'b1;
        if (do_ab && c == ab_at) m_abort = 1'b1;
        tick();
        m_start = 1'b0;
        if (do_ab && c == ab_at) begin
          m_abort = 1'b0;
          caps = (c - 1) / (M_SET + 1);
          check("m_abort_busy", 64'(m_busy), 64'd0);
          check("m_abort_done", 64'(m_done), 64'd0);
          check("m_abort_dut_in", 64'(m_in), 64'd0);
          check("m_abort_sig", 64'(m_sig_o), 64'(m_expect(caps)));
          check("m_abort_pass", 64'(m_pass), 64'd0);
          break;
        end
      end
    end
    repeat (5) tick();
    check("m_scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
